// File: rtl/sprite_line_server.sv
// Serves sprite line fetches from the graphic RAM: one back-to-back grant per active sprite per window.
// Read data is registered, so it is valid the cycle after the grant; the host write port is live in every state.
module sprite_line_server #(
  parameter int N_SPRITES      = 4,
  parameter int WIDTH          = 8,
  parameter int ADDR_WIDTH     = 9,
  parameter int MEM_ADDR_WIDTH = 11
) (
  input  logic                                pixel_clock,
  input  logic                                reset_n,
  input  logic                                line_start,
  input  logic [N_SPRITES-1:0]                active,
  input  logic [N_SPRITES*MEM_ADDR_WIDTH-1:0] base,
  input  logic [N_SPRITES*ADDR_WIDTH-1:0]     pos,
  output logic [N_SPRITES-1:0]                dma_avail,
  output logic [WIDTH-1:0]                    data,
  output logic                                busy,
  input  logic                                wr_en,
  input  logic [MEM_ADDR_WIDTH-1:0]           wr_addr,
  input  logic [WIDTH-1:0]                    wr_data
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [N_SPRITES-1:0]      mask_q, mask_d;
  logic [WIDTH-1:0]          data_q;
  logic [N_SPRITES-1:0]      grant;
  logic [MEM_ADDR_WIDTH-1:0] sel_base;
  logic [ADDR_WIDTH-1:0]     sel_pos;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr;

  logic [WIDTH-1:0] ram [0:DEPTH-1];

  // Priority pick of the lowest pending sprite; depends only on the latched mask.
  always_comb begin
    grant    = '0;
    sel_base = '0;
    sel_pos  = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        grant    = N_SPRITES'(1) << i;
        sel_base = base[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        sel_pos  = pos[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign rd_addr = sel_base + MEM_ADDR_WIDTH'(sel_pos);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (line_start) begin
          mask_d = active;
          if (|active) state_d = GRANT;
        end
      end
      GRANT: begin
        mask_d = mask_q & ~grant;
        if (mask_d == '0) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Both processes read the array before the write lands, giving read-first behaviour on collisions.
  always_ff @(posedge pixel_clock) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (state_q == GRANT) begin
      data_q <= ram[rd_addr];
    end
  end

  assign dma_avail = (state_q == GRANT) ? grant : '0;
  assign data      = data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_line_server.sv
// Directed bench for sprite_line_server: grant order, data latency, wrap, read-first collision, reset, mid-window events.
module tb_sprite_line_server;

  localparam int NS = 4;
  localparam int W  = 8;
  localparam int AW = 9;
  localparam int MW = 11;

  logic             pixel_clock;
  logic             reset_n;
  logic             line_start;
  logic [NS-1:0]    active;
  logic [NS*MW-1:0] base;
  logic [NS*AW-1:0] pos;
  logic [NS-1:0]    dma_avail;
  logic [W-1:0]     data;
  logic             busy;
  logic             wr_en;
  logic [MW-1:0]    wr_addr;
  logic [W-1:0]     wr_data;

  int n_chk  = 0;
  int n_pass = 0;

  sprite_line_server #(
    .N_SPRITES(NS), .WIDTH(W), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW)
  ) dut (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .line_start(line_start),
    .active(active), .base(base), .pos(pos), .dma_avail(dma_avail),
    .data(data), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial begin
    pixel_clock = 1'b0;
    forever #5 pixel_clock = ~pixel_clock;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic set_sprite(input int k, input logic [MW-1:0] b, input logic [AW-1:0] p);
    base[k*MW +: MW] = b;
    pos[k*AW +: AW]  = p;
  endtask

  task automatic default_sprites();
    for (int k = 0; k < NS; k++) set_sprite(k, MW'(k * 16), AW'(k));
  endtask

  initial begin
    reset_n    = 1'b0;
    line_start = 1'b0;
    active     = '0;
    base       = '0;
    pos        = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    repeat (2) @(posedge pixel_clock);
    #1;
    check("rst_dma", 32'(dma_avail), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    reset_n = 1'b1;

    // Preload RAM[a] = a[7:0]
    for (int a = 0; a < (1 << MW); a++) begin
      wr_en   = 1'b1;
      wr_addr = MW'(a);
      wr_data = 8'(a);
      tick();
    end
    wr_en = 1'b0;

    // Full window
    default_sprites();
    active     = 4'b1111;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("full_T0_dma", 32'(dma_avail), 32'h1);
    check("full_T0_busy", 32'(busy), 32'h1);
    tick();
    check("full_T1_dma", 32'(dma_avail), 32'h2);
    check("full_T1_data", 32'(data), 32'h00);
    tick();
    check("full_T2_dma", 32'(dma_avail), 32'h4);
    check("full_T2_data", 32'(data), 32'h11);
    tick();
    check("full_T3_dma", 32'(dma_avail), 32'h8);
    check("full_T3_data", 32'(data), 32'h22);
    tick();
    check("full_drain_dma", 32'(dma_avail), 32'h0);
    check("full_drain_data", 32'(data), 32'h33);
    check("full_drain_busy", 32'(busy), 32'h1);
    tick();
    check("full_idle_busy", 32'(busy), 32'h0);
    check("full_idle_data", 32'(data), 32'h33);

    // Reset mid-GRANT
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    check("pre_rst_dma", 32'(dma_avail), 32'h4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dma", 32'(dma_avail), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_data", 32'(data), 32'h0);
    @(negedge pixel_clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_dma", 32'(dma_avail), 32'h0);
      check("post_rst_busy", 32'(busy), 32'h0);
    end

    // Sparse mask
    active     = 4'b1010;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("sparse_g0_dma", 32'(dma_avail), 32'h2);
    tick();
    check("sparse_g1_dma", 32'(dma_avail), 32'h8);
    check("sparse_g1_data", 32'(data), 32'h11);
    tick();
    check("sparse_drain_dma", 32'(dma_avail), 32'h0);
    check("sparse_drain_busy", 32'(busy), 32'h1);
    check("sparse_drain_data", 32'(data), 32'h33);
    tick();
    check("sparse_idle_busy", 32'(busy), 32'h0);

    // Empty mask never opens a window
    active     = 4'b0000;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("empty_busy0", 32'(busy), 32'h0);
    check("empty_dma0", 32'(dma_avail), 32'h0);
    tick();
    check("empty_busy1", 32'(busy), 32'h0);

    // Address wrap: 0x7FF + 2 -> 0x001
    set_sprite(0, 11'h7FF, 9'd2);
    active     = 4'b0001;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("wrap_dma", 32'(dma_avail), 32'h1);
    tick();
    check("wrap_data", 32'(data), 32'h01);
    tick();
    check("wrap_idle_busy", 32'(busy), 32'h0);

    // Write collision, read-first
    wr_en   = 1'b1;
    wr_addr = 11'h123;
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    set_sprite(2, 11'h120, 9'd3);
    active     = 4'b0100;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("coll_dma", 32'(dma_avail), 32'h4);
    wr_en   = 1'b1;
    wr_addr = 11'h123;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("coll_old_data", 32'(data), 32'h3C);
    tick();
    tick();
    check("coll_idle_busy", 32'(busy), 32'h0);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    check("coll_new_data", 32'(data), 32'hA5);
    tick();
    tick();

    // Mid-window line_start and active change
    default_sprites();
    active     = 4'b1101;
    line_start = 1'b1;
    tick();
    check("mid_g0_dma", 32'(dma_avail), 32'h1);
    active = 4'b0010;
    tick();
    check("mid_g1_dma", 32'(dma_avail), 32'h4);
    check("mid_g1_data", 32'(data), 32'h00);
    tick();
    check("mid_g2_dma", 32'(dma_avail), 32'h8);
    check("mid_g2_data", 32'(data), 32'h22);
    tick();
    check("mid_drain_dma", 32'(dma_avail), 32'h0);
    check("mid_drain_busy", 32'(busy), 32'h1);
    check("mid_drain_data", 32'(data), 32'h33);
    line_start = 1'b0;
    tick();
    check("mid_idle_busy", 32'(busy), 32'h0);
    tick();
    check("mid_idle2_busy", 32'(busy), 32'h0);
    check("mid_idle2_dma", 32'(dma_avail), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
